// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared types and constants for the write-back stage of the pipelined ARM CPU.
//   ld_size_t     : load access size (byte / half / word / dword)
//   wb_payload_t  : MEM/WB payload at the default datapath widths (64/32)
//   LINK_REG_DEF  : register written by BL (X30)
//   ZERO_REG_DEF  : register that is never written (XZR)
// -----------------------------------------------------------------------------
package wb_pkg;

    localparam int LINK_REG_DEF = 30;
    localparam int ZERO_REG_DEF = 31;

    localparam int PKG_DATA_W  = 64;
    localparam int PKG_INSTR_W = 32;

    typedef enum logic [1:0] {
        LD_B = 2'b00,
        LD_H = 2'b01,
        LD_W = 2'b10,
        LD_D = 2'b11
    } ld_size_t;

    typedef struct packed {
        logic [PKG_DATA_W-1:0]  alu_result;
        logic [PKG_DATA_W-1:0]  mem_data;
        logic [PKG_DATA_W-1:0]  incr4;
        logic [PKG_INSTR_W-1:0] instr;
        logic                   mem_to_reg;
        logic                   bl_branch;
        logic                   reg_write;
        ld_size_t               ld_size;
        logic                   ld_signed;
    } wb_payload_t;

endpackage

// File: rtl/wb_load_ext.sv
// -----------------------------------------------------------------------------
// wb_load_ext
// Combinational load-data extender. Picks the low 8/16/32/64 bits of the raw
// memory word according to ld_size and sign- or zero-extends them to DATA_W.
// A dword load passes the full word and ignores ld_signed.
// Ports:
//   mem_data  in  DATA_W  raw data-memory read data
//   ld_size   in  2       access size (ld_size_t)
//   ld_signed in  1       sign-extend when set, zero-extend otherwise
//   load_data out DATA_W  extended load value
// DATA_W must be greater than 32.
// -----------------------------------------------------------------------------
module wb_load_ext
    import wb_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [DATA_W-1:0] mem_data,
    input  ld_size_t          ld_size,
    input  logic              ld_signed,
    output logic [DATA_W-1:0] load_data
);

    function automatic logic [DATA_W-1:0] load_extend(
        input logic [DATA_W-1:0] d,
        input ld_size_t          sz,
        input logic              sgn
    );
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] w;
        logic [DATA_W-1:0]  r;
        b = $signed(d[7:0]);
        h = $signed(d[15:0]);
        w = $signed(d[31:0]);
        case (sz)
            LD_B:    r = sgn ? {{(DATA_W-8){b[7]}},   b} : {{(DATA_W-8){1'b0}},  d[7:0]};
            LD_H:    r = sgn ? {{(DATA_W-16){h[15]}}, h} : {{(DATA_W-16){1'b0}}, d[15:0]};
            LD_W:    r = sgn ? {{(DATA_W-32){w[31]}}, w} : {{(DATA_W-32){1'b0}}, d[31:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    assign load_data = load_extend(mem_data, ld_size, ld_signed);

endmodule

// File: rtl/wb_stage_pipe.sv
// -----------------------------------------------------------------------------
// wb_stage_pipe
// Registered write-back stage. Captures the MEM/WB payload, selects the
// register-file write data (BL return address > load data > ALU result),
// derives destination register and gated write enable, mirrors them onto the
// EX forwarding bus and counts instructions accepted into WB.
// Edge priority: reset > flush > stall > capture.
//
// Optional build macro: WB_LOAD_EXT_EN
//   defined   : load data is size-selected and sign/zero-extended (wb_load_ext)
//   undefined : memory data passes unmodified; ld_size/ld_signed are ignored
//
// Ports:
//   clk, reset (sync, active-high)
//   in_valid, in_alu_result, in_mem_data, in_incr4, in_instr,
//   in_mem_to_reg, in_bl_branch, in_reg_write, in_ld_size, in_ld_signed
//                                   MEM-stage payload
//   stall, flush                    hazard-unit controls
//   wb_valid, wb_reg_write, wb_dest_reg, wb_write_data
//                                   register-file write port
//   fwd_valid, fwd_reg, fwd_data    forwarding bus (mirrors write port)
//   retired_count                   accepted-instruction counter (wraps)
// -----------------------------------------------------------------------------
module wb_stage_pipe
    import wb_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int INSTR_W  = 32,
    parameter int REG_AW   = 5,
    parameter int LINK_REG = LINK_REG_DEF,
    parameter int ZERO_REG = ZERO_REG_DEF,
    parameter int CNT_W    = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_alu_result,
    input  logic [DATA_W-1:0]  in_mem_data,
    input  logic [DATA_W-1:0]  in_incr4,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               in_mem_to_reg,
    input  logic               in_bl_branch,
    input  logic               in_reg_write,
    input  logic [1:0]         in_ld_size,
    input  logic               in_ld_signed,
    input  logic               stall,
    input  logic               flush,
    output logic               wb_valid,
    output logic               wb_reg_write,
    output logic [REG_AW-1:0]  wb_dest_reg,
    output logic [DATA_W-1:0]  wb_write_data,
    output logic               fwd_valid,
    output logic [REG_AW-1:0]  fwd_reg,
    output logic [DATA_W-1:0]  fwd_data,
    output logic [CNT_W-1:0]   retired_count
);

    localparam logic [REG_AW-1:0] LINK_A = REG_AW'(LINK_REG);
    localparam logic [REG_AW-1:0] ZERO_A = REG_AW'(ZERO_REG);

    // Same layout as wb_payload_t, sized by this instance's parameters.
    typedef struct packed {
        logic [DATA_W-1:0]  alu_result;
        logic [DATA_W-1:0]  mem_data;
        logic [DATA_W-1:0]  incr4;
        logic [INSTR_W-1:0] instr;
        logic               mem_to_reg;
        logic               bl_branch;
        logic               reg_write;
        ld_size_t           ld_size;
        logic               ld_signed;
    } payload_t;

    payload_t          pl_in;
    payload_t          pl_p0;
    logic              vld_p0;
    logic [CNT_W-1:0]  cnt_p0;
    logic [DATA_W-1:0] load_data;
    logic [REG_AW-1:0] dest_reg;
    logic [DATA_W-1:0] write_data;
    logic              reg_we;

    always_comb begin
        pl_in.alu_result = in_alu_result;
        pl_in.mem_data   = in_mem_data;
        pl_in.incr4      = in_incr4;
        pl_in.instr      = in_instr;
        pl_in.mem_to_reg = in_mem_to_reg;
        pl_in.bl_branch  = in_bl_branch;
        pl_in.reg_write  = in_reg_write;
        pl_in.ld_size    = ld_size_t'(in_ld_size);
        pl_in.ld_signed  = in_ld_signed;
    end

    // ---- MEM/WB boundary: p0 registers ----
    // A flush only clears the valid bit; the stale payload is harmless because
    // every enable derived from it is gated by vld_p0.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0 <= 1'b0;
            pl_p0  <= '0;
            cnt_p0 <= '0;
        end else if (flush) begin
            vld_p0 <= 1'b0;
        end else if (!stall) begin
            vld_p0 <= in_valid;
            pl_p0  <= pl_in;
            if (in_valid) begin
                cnt_p0 <= cnt_p0 + CNT_W'(1);
            end
        end
    end

    // ---- WB outputs: combinational from p0 only ----
`ifdef WB_LOAD_EXT_EN
    wb_load_ext #(
        .DATA_W (DATA_W)
    ) u_load_ext (
        .mem_data  (pl_p0.mem_data),
        .ld_size   (pl_p0.ld_size),
        .ld_signed (pl_p0.ld_signed),
        .load_data (load_data)
    );
`else
    logic unused_ld_fields;
    assign load_data        = pl_p0.mem_data;
    assign unused_ld_fields = ^{pl_p0.ld_size, pl_p0.ld_signed};
`endif

    logic unused_instr_hi;
    assign unused_instr_hi = ^pl_p0.instr[INSTR_W-1:REG_AW];

    always_comb begin
        dest_reg = pl_p0.bl_branch ? LINK_A : pl_p0.instr[REG_AW-1:0];

        if (pl_p0.bl_branch) begin
            write_data = pl_p0.incr4;
        end else if (pl_p0.mem_to_reg) begin
            write_data = load_data;
        end else begin
            write_data = pl_p0.alu_result;
        end

        // Held entries keep the enable asserted during stall; rewriting the
        // same address with the same data is harmless.
        reg_we = vld_p0 & (pl_p0.reg_write | pl_p0.bl_branch) & (dest_reg != ZERO_A);
    end

    assign wb_valid      = vld_p0;
    assign wb_reg_write  = reg_we;
    assign wb_dest_reg   = dest_reg;
    assign wb_write_data = write_data;
    assign fwd_valid     = reg_we;
    assign fwd_reg       = dest_reg;
    assign fwd_data      = write_data;
    assign retired_count = cnt_p0;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// -----------------------------------------------------------------------------
// tb_wb_stage_pipe
// Directed-vector bench for wb_stage_pipe with a scoreboard queue: the driver
// pushes the hand-computed state expected after each clock edge, and an
// independent monitor pops and compares on the falling edge.
// Honours WB_LOAD_EXT_EN for the load-extension expectations.
// -----------------------------------------------------------------------------
module tb_wb_stage_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [63:0] in_alu_result;
    logic [63:0] in_mem_data;
    logic [63:0] in_incr4;
    logic [31:0] in_instr;
    logic        in_mem_to_reg;
    logic        in_bl_branch;
    logic        in_reg_write;
    logic [1:0]  in_ld_size;
    logic        in_ld_signed;
    logic        stall;
    logic        flush;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [4:0]  wb_dest_reg;
    logic [63:0] wb_write_data;
    logic        fwd_valid;
    logic [4:0]  fwd_reg;
    logic [63:0] fwd_data;
    logic [31:0] retired_count;

    always #5 clk = ~clk;

    wb_stage_pipe dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_alu_result (in_alu_result),
        .in_mem_data   (in_mem_data),
        .in_incr4      (in_incr4),
        .in_instr      (in_instr),
        .in_mem_to_reg (in_mem_to_reg),
        .in_bl_branch  (in_bl_branch),
        .in_reg_write  (in_reg_write),
        .in_ld_size    (in_ld_size),
        .in_ld_signed  (in_ld_signed),
        .stall         (stall),
        .flush         (flush),
        .wb_valid      (wb_valid),
        .wb_reg_write  (wb_reg_write),
        .wb_dest_reg   (wb_dest_reg),
        .wb_write_data (wb_write_data),
        .fwd_valid     (fwd_valid),
        .fwd_reg       (fwd_reg),
        .fwd_data      (fwd_data),
        .retired_count (retired_count)
    );

    typedef struct {
        string       name;
        logic        v;
        logic        rw;
        logic [4:0]  dest;
        logic [63:0] data;
        logic [31:0] cnt;
        bit          chk_data;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check1(input string nm, input string fld, input logic [63:0] act,
                          input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, fld, act, req);
        end
    endtask

    // Monitor: compares presented outputs against the oldest expectation.
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            check1(e.name, "wb_valid",      {63'd0, wb_valid},     {63'd0, e.v});
            check1(e.name, "wb_reg_write",  {63'd0, wb_reg_write}, {63'd0, e.rw});
            check1(e.name, "fwd_valid",     {63'd0, fwd_valid},    {63'd0, e.rw});
            check1(e.name, "retired_count", {32'd0, retired_count}, {32'd0, e.cnt});
            if (e.chk_data) begin
                check1(e.name, "wb_dest_reg",   {59'd0, wb_dest_reg}, {59'd0, e.dest});
                check1(e.name, "fwd_reg",       {59'd0, fwd_reg},     {59'd0, e.dest});
                check1(e.name, "wb_write_data", wb_write_data, e.data);
                check1(e.name, "fwd_data",      fwd_data,      e.data);
            end
        end
    end

    // Apply one set of inputs across one rising edge.
    task automatic drive(input logic rs, input logic st, input logic fl, input logic v,
                         input logic [63:0] alu, input logic [63:0] mem,
                         input logic [63:0] inc, input logic [31:0] ins,
                         input logic m2r, input logic bl, input logic rw,
                         input logic [1:0] sz, input logic sg);
        @(negedge clk);
        reset         = rs;
        stall         = st;
        flush         = fl;
        in_valid      = v;
        in_alu_result = alu;
        in_mem_data   = mem;
        in_incr4      = inc;
        in_instr      = ins;
        in_mem_to_reg = m2r;
        in_bl_branch  = bl;
        in_reg_write  = rw;
        in_ld_size    = sz;
        in_ld_signed  = sg;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string nm, input logic v, input logic rw,
                                input logic [4:0] dest, input logic [63:0] data,
                                input logic [31:0] cnt, input bit chk_data);
        exp_t e;
        e.name = nm; e.v = v; e.rw = rw; e.dest = dest; e.data = data;
        e.cnt = cnt; e.chk_data = chk_data;
        sbq.push_back(e);
    endtask

    localparam logic [63:0] MEM_NEG = 64'hFFFF_FFFF_FFFF_FF80;

`ifdef WB_LOAD_EXT_EN
    localparam logic [63:0] EXP_B_U = 64'h0000_0000_0000_0080;
    localparam logic [63:0] EXP_H_S = 64'hFFFF_FFFF_FFFF_8001;
    localparam logic [63:0] EXP_W_U = 64'h0000_0000_8000_0001;
    localparam logic [63:0] EXP_W_S = 64'hFFFF_FFFF_8000_0001;
`else
    localparam logic [63:0] EXP_B_U = 64'hFFFF_FFFF_FFFF_FF80;
    localparam logic [63:0] EXP_H_S = 64'h0000_0000_1234_8001;
    localparam logic [63:0] EXP_W_U = 64'hAAAA_BBBB_8000_0001;
    localparam logic [63:0] EXP_W_S = 64'hAAAA_BBBB_8000_0001;
`endif

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
        in_alu_result = '0; in_mem_data = '0; in_incr4 = '0; in_instr = '0;
        in_mem_to_reg = 1'b0; in_bl_branch = 1'b0; in_reg_write = 1'b0;
        in_ld_size = 2'b00; in_ld_signed = 1'b0;

        // reset held two cycles with a valid, writing instruction on the inputs
        drive(1, 0, 0, 1, 64'hDEAD, 64'hBEEF, 64'h44, 32'd5, 0, 0, 1, 2'b00, 0);
        expect_state("reset0", 0, 0, 5'd0, 64'h0, 32'd0, 1);
        drive(1, 0, 0, 1, 64'hDEAD, 64'hBEEF, 64'h44, 32'd5, 0, 0, 1, 2'b00, 0);
        expect_state("reset1", 0, 0, 5'd0, 64'h0, 32'd0, 1);

        // ALU result to X5
        drive(0, 0, 0, 1, 64'h1234, 64'h9, 64'h8, 32'h0000_0005, 0, 0, 1, 2'b11, 0);
        expect_state("alu_x5", 1, 1, 5'd5, 64'h1234, 32'd1, 1);

        // BL beats mem_to_reg; destination forced to X30
        drive(0, 0, 0, 1, 64'h77, 64'h5555, 64'h400, 32'h0000_0003, 1, 1, 0, 2'b11, 0);
        expect_state("bl_link", 1, 1, 5'd30, 64'h400, 32'd2, 1);

        // write to XZR is suppressed while the entry stays valid
        drive(0, 0, 0, 1, 64'h77, 64'h0, 64'h0, 32'h0000_001F, 0, 0, 1, 2'b11, 0);
        expect_state("xzr", 1, 0, 5'd31, 64'h77, 32'd3, 1);

        // signed byte load
        drive(0, 0, 0, 1, 64'h1, MEM_NEG, 64'h0, 32'h0000_0007, 1, 0, 1, 2'b00, 1);
        expect_state("ldb_s", 1, 1, 5'd7, MEM_NEG, 32'd4, 1);

        // unsigned byte load
        drive(0, 0, 0, 1, 64'h1, MEM_NEG, 64'h0, 32'h0000_0008, 1, 0, 1, 2'b00, 0);
        expect_state("ldb_u", 1, 1, 5'd8, EXP_B_U, 32'd5, 1);

        // stall three cycles with new inputs: everything holds, enable stays up
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 1, 64'h9999, 64'h0, 64'h0, 32'h0000_0009, 0, 0, 1, 2'b11, 0);
            expect_state("stall", 1, 1, 5'd8, EXP_B_U, 32'd5, 1);
        end

        // stall + flush: bubble, not counted
        drive(0, 1, 1, 1, 64'h9999, 64'h0, 64'h0, 32'h0000_0009, 0, 0, 1, 2'b11, 0);
        expect_state("stall_flush", 0, 0, 5'd0, 64'h0, 32'd5, 0);

        // capture resumes
        drive(0, 0, 0, 1, 64'hABC, 64'h0, 64'h0, 32'h0000_000C, 0, 0, 1, 2'b11, 0);
        expect_state("alu_x12", 1, 1, 5'd12, 64'hABC, 32'd6, 1);

        // signed half load
        drive(0, 0, 0, 1, 64'h0, 64'h0000_0000_1234_8001, 64'h0, 32'h0000_0002, 1, 0, 1, 2'b01, 1);
        expect_state("ldh_s", 1, 1, 5'd2, EXP_H_S, 32'd7, 1);

        // word loads, unsigned then signed
        drive(0, 0, 0, 1, 64'h0, 64'hAAAA_BBBB_8000_0001, 64'h0, 32'h0000_0004, 1, 0, 1, 2'b10, 0);
        expect_state("ldw_u", 1, 1, 5'd4, EXP_W_U, 32'd8, 1);
        drive(0, 0, 0, 1, 64'h0, 64'hAAAA_BBBB_8000_0001, 64'h0, 32'h0000_0004, 1, 0, 1, 2'b10, 1);
        expect_state("ldw_s", 1, 1, 5'd4, EXP_W_S, 32'd9, 1);

        // dword load ignores ld_signed; upper instruction bits do not leak into Rd
        drive(0, 0, 0, 1, 64'h0, 64'h8123_4567_89AB_CDEF, 64'h0, 32'hFFFF_FFE6, 1, 0, 1, 2'b11, 1);
        expect_state("ldd", 1, 1, 5'd6, 64'h8123_4567_89AB_CDEF, 32'd10, 1);

        // idle slot: payload captured but not valid, not counted
        drive(0, 0, 0, 0, 64'h55, 64'h0, 64'h0, 32'h0000_0001, 0, 0, 1, 2'b11, 0);
        expect_state("idle", 0, 0, 5'd1, 64'h55, 32'd10, 1);

        // valid entry then flush alone
        drive(0, 0, 0, 1, 64'h66, 64'h0, 64'h0, 32'h0000_000A, 0, 0, 1, 2'b11, 0);
        expect_state("alu_x10", 1, 1, 5'd10, 64'h66, 32'd11, 1);
        drive(0, 0, 1, 1, 64'h67, 64'h0, 64'h0, 32'h0000_000B, 0, 0, 1, 2'b11, 0);
        expect_state("flush", 0, 0, 5'd0, 64'h0, 32'd11, 0);

        // reset in the middle clears the counter again
        drive(1, 0, 0, 1, 64'h67, 64'h0, 64'h0, 32'h0000_000B, 0, 0, 1, 2'b11, 0);
        expect_state("reset_mid", 0, 0, 5'd0, 64'h0, 32'd0, 1);

        drive(0, 0, 0, 0, 64'h0, 64'h0, 64'h0, 32'h0, 0, 0, 0, 2'b00, 0);
        expect_state("post_reset", 0, 0, 5'd0, 64'h0, 32'd0, 1);

        for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
        if (sbq.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", sbq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_stage_pipe.md
Name: wb_stage_pipe

Overview:
Registered, parametrised write-back stage for the pipelined ARM CPU. It captures the MEM/WB pipeline payload and selects the register-file write data from ALU result, memory data or return address (BL). It also derives the destination register and a gated write enable, drives a forwarding bus for the EX stage, and counts retired instructions. It supports stall (hold) and flush (bubble) from the hazard unit.

Parameters:
DATA_W, 64, datapath width (ALU result, memory data, PC+4, write data)
INSTR_W, 32, instruction width carried down the pipe
REG_AW, 5, register address width
LINK_REG, 30, destination register forced on BL
ZERO_REG, 31, register that is never written (XZR)
CNT_W, 32, retired-instruction counter width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  MEM stage holds a real instruction
in_alu_result  in  DATA_W  ALU result from MEM stage
in_mem_data  in  DATA_W  data-memory read data
in_incr4  in  DATA_W  PC+4 (BL return address)
in_instr  in  INSTR_W  instruction word; Rd = bits [REG_AW-1:0]
in_mem_to_reg  in  1  select memory data over ALU result
in_bl_branch  in  1  BL: write in_incr4 to LINK_REG
in_reg_write  in  1  instruction writes the register file
in_ld_size  in  2  load size: 00 byte, 01 half, 10 word, 11 dword
in_ld_signed  in  1  sign-extend load data
stall  in  1  hold the current WB contents
flush  in  1  insert a bubble
wb_valid  out  1  stage holds a valid instruction
wb_reg_write  out  1  register-file write enable
wb_dest_reg  out  REG_AW  register-file write address
wb_write_data  out  DATA_W  register-file write data
fwd_valid  out  1  forwarding entry valid (= wb_reg_write)
fwd_reg  out  REG_AW  forwarding register (= wb_dest_reg)
fwd_data  out  DATA_W  forwarding data (= wb_write_data)
retired_count  out  CNT_W  instructions accepted into WB

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset: all payload registers, wb_valid and retired_count are 0. All outputs therefore read 0.
- Priority per rising edge is reset > flush > stall > capture.
  - flush: wb_valid <= 0. Payload is don't-care but must be gated so the write and forwarding enables are 0.
  - stall: every register holds its value.
  - capture: wb_valid <= in_valid and all in_* fields are registered.
- Latency: outputs reflect the inputs sampled at the previous accepted edge (1 cycle). Outputs are combinational from the registered state only; there is no input-to-output combinational path.
- Destination register:
  - wb_dest_reg = LINK_REG if registered bl_branch is set.
  - Otherwise wb_dest_reg = instr[REG_AW-1:0].
- Write enable: wb_reg_write = wb_valid & (reg_write | bl_branch) & (wb_dest_reg != ZERO_REG).
- Write data priority is bl_branch > mem_to_reg > ALU:
  - bl_branch: incr4.
  - mem_to_reg: load data (see Optional Feature).
  - otherwise: alu_result.
- Stall with a valid entry: wb_reg_write stays asserted on every held cycle. The rewrite is idempotent because the same address and data are presented.
- Counter:
  - retired_count increments by 1 on each edge where in_valid & ~stall & ~flush & ~reset.
  - It wraps modulo 2^CNT_W.
  - A flush discards the incoming instruction without counting it.
- Simultaneous stall and flush: flush wins and the stage becomes a bubble.

Optional Feature:
WB_LOAD_EXT_EN
- Defined: when mem_to_reg is set, load data is taken from the low bits of mem_data by in_ld_size (8/16/32/64 bits). It is sign-extended when ld_signed is set, zero-extended otherwise. Size 11 passes the full width and ld_signed is ignored.
- Undefined: mem_data passes unmodified. The ld_size and ld_signed ports remain, are registered or optimised away, and are ignored.

Decomposition:
- Shared package wb_pkg:
  - typedef ld_size_t (enum LD_B, LD_H, LD_W, LD_D);
  - packed struct wb_payload_t (alu_result, mem_data, incr4, instr, mem_to_reg, bl_branch, reg_write, ld_size, ld_signed);
  - constants LINK_REG_DEF = 30 and ZERO_REG_DEF = 31.
- One natural sub-module, wb_load_ext: combinational load-data extender, instantiated only under WB_LOAD_EXT_EN.

Test Plan:
- reset held 2 cycles with in_valid=1 -> wb_valid=0, wb_reg_write=0, retired_count=0, all data outputs 0.
- ALU op: in_alu_result=0x1234, instr Rd=5, reg_write=1 -> next cycle wb_dest_reg=5, wb_write_data=0x1234, wb_reg_write=1, fwd_* mirror; retired_count=1.
- BL with mem_to_reg=1 and instr Rd=3, in_incr4=0x400 -> wb_dest_reg=30, wb_write_data=0x400 (BL over mem priority).
- Rd=31 with reg_write=1 -> wb_reg_write=0 and fwd_valid=0, while wb_valid=1.
- Stall 3 cycles with new inputs applied -> outputs unchanged, counter unchanged. Then stall+flush together -> wb_valid=0 and the counter does not increment.
- WB_LOAD_EXT_EN, mem_data=0xFFFF_FFFF_FFFF_FF80, mem_to_reg=1, size=byte -> signed gives 0xFFFF_FFFF_FFFF_FF80, unsigned gives 0x80. Without the macro -> the full value passes.
